// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared encodings for the multicycle control unit
// Holds the FSM state enum, opcode constants, ALUControl codes, mux select
// encodings and the immediate-format helper. The JAL state exists only when
// JAL_EN is defined.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_HALTED
`ifdef JAL_EN
    , S_JAL
`endif
  } state_t;

  // Operation class handed to the ALU decoder.
  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_for(input logic [6:0] opcode);
    case (opcode)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational ALUControl decode
// Ports: alu_op (operation class from the FSM), funct3, op_5 (opcode bit 5,
// set for R-type), funct7_5; alu_control is the 3-bit code zero-extended
// to ALU_CTRL_W.
module alu_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  alu_op_t               alu_op,
  input  logic [2:0]            funct3,
  input  logic                  op_5,
  input  logic                  funct7_5,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  logic [2:0] code;

  always_comb begin
    code = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7_5 is part of the immediate for I-type, so only R-type subtracts
          3'b000:  code = (op_5 && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  code = ALU_SLL;
          3'b010:  code = ALU_SLT;
          3'b100:  code = ALU_XOR;
          3'b101:  code = ALU_SRL;
          3'b110:  code = ALU_OR;
          3'b111:  code = ALU_AND;
          default: code = ALU_ADD;
        endcase
      end
      default: code = ALU_ADD;
    endcase
  end

  assign alu_control = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle RISC-V control FSM
// Inputs: clk, rst (async, active high), op/funct3/funct7_5 of the current
// instruction, ZF/SF ALU flags, mem_ready handshake.
// Outputs: datapath enables and mux selects, mem_req, HALT, mem_err (sticky
// memory timeout), instret (retired-instruction count).
// Define JAL_EN to add the JAL state; otherwise JAL decodes as illegal.
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W  = 3,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  input  logic                  ZF,
  input  logic                  SF,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  AdrSrc,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic                  MemWrite,
  output logic                  RegWrite,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ImmSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  HALT,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      instret
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              mem_err_q, mem_err_d;
  logic              mem_wait;
  logic              timeout_hit;
  logic              branch_taken;
  alu_op_t           alu_op;

  // wait_q counts cycles already spent waiting, so the final allowed cycle
  // is MEM_TIMEOUT-1; a mem_ready on that cycle still completes the access.
  assign timeout_hit = (MEM_TIMEOUT > 0) && (int'(wait_q) == MEM_TIMEOUT - 1);

  always_comb begin
    case (funct3)
      3'b000:  branch_taken = ZF;
      3'b001:  branch_taken = ~ZF;
      3'b100:  branch_taken = SF;
      3'b101:  branch_taken = ~SF;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    mem_err_d = mem_err_q;
    instret_d = instret_q;
    mem_wait  = 1'b0;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;   else mem_wait = 1'b1;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;    else mem_wait = 1'b1;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;    else mem_wait = 1'b1;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
`ifdef JAL_EN
          OP_JAL:            state_d = S_JAL;
`endif
          default:           state_d = S_HALTED;
        endcase
      end
      S_MEMADR:         state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMWB:          state_d = S_FETCH;
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_ALUWB:          state_d = S_FETCH;
      S_BRANCH:         state_d = S_FETCH;
`ifdef JAL_EN
      S_JAL:            state_d = S_ALUWB;
`endif
      S_HALTED:         state_d = S_HALTED;
      default:          state_d = S_HALTED;
    endcase

    // Counter only advances while parked in a memory state; any state change
    // (including entering FETCH/MEMREAD/MEMWRITE) leaves it at zero.
    if (mem_wait && (MEM_TIMEOUT > 0)) begin
      if (timeout_hit) begin
        state_d   = S_HALTED;
        mem_err_d = 1'b1;
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end

    if ((state_d == S_FETCH) && (state_q != S_FETCH)) instret_d = instret_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ResultSrc = RES_ALUOUT;
    ImmSrc    = IMM_I;
    alu_op    = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURES;
        end
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = imm_src_for(op);
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = imm_src_for(op);
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        ResultSrc = RES_DATA;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = imm_src_for(op);
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        // ALU compares rs1-rs2 for the flags; ALUOut already holds the target
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ImmSrc  = imm_src_for(op);
        alu_op  = ALUOP_SUB;
        PCWrite = branch_taken;
      end
`ifdef JAL_EN
      S_JAL: begin
        PCWrite = 1'b1;
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        ImmSrc  = imm_src_for(op);
      end
`endif
      default: ;
    endcase
    // Reset lands in FETCH, which would otherwise fire IRWrite/PCWrite on mem_ready.
    if (rst) begin
      mem_req  = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op_5        (op[5]),
    .funct7_5    (funct7_5),
    .alu_control (ALUControl)
  );

  assign HALT    = (state_q == S_HALTED);
  assign mem_err = mem_err_q;
  assign instret = instret_q;

endmodule
